mips_mem_responder: RTL

- Memory-side responder for the single-cycle MIPS core: serves instruction fetch (PC -> instruction) and data memory (dm_address/dm_d/dm_we -> dm_q).
- Contains a boot loader FSM that fills instruction memory from a byte stream (valid/ready) before releasing the core via core_run.
- Sits between the core and the board-level loader link; the core runs only while core_run=1.

---
 rtl/mips_mem_responder.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/mips_mem_responder.sv
// mips_mem_responder: instruction/data memory responder with a byte-stream boot loader for the MIPS core.
// Latency: fetch and load reads are combinational; stores and loader writes land on the rising edge; core_run rises the cycle after the final image byte.
// Backpressure: ld_ready is high in every loading state and low once RUN is reached, so bytes offered after the load are never taken.
//
// Ports:
//   clk, asyn_n_rst           clock and asynchronous active-low reset
//   PC -> instruction          word-addressed fetch, zero when out of range or not running
//   dm_address/dm_d/dm_we      data memory access, dm_q is the pre-edge read value
//   ld_valid/ld_byte/ld_ready  loader byte stream: 16-bit LE word count, then LE payload words
//   core_run, im_ovf, dm_err   run enable, sticky image-overflow flag, sticky data range error
// Optional: define LOAD_CHECKSUM_EN to require a trailing XOR checksum byte after the image.
module mips_mem_responder #(
   parameter int IM_AW = 8,
   parameter int DM_AW = 8
) (
   input  logic        clk,
   input  logic        asyn_n_rst,
   input  logic [31:0] PC,
   output logic [31:0] instruction,
   input  logic [15:0] dm_address,
   input  logic [31:0] dm_d,
   input  logic        dm_we,
   output logic [31:0] dm_q,
   input  logic        ld_valid,
   input  logic [7:0]  ld_byte,
   output logic        ld_ready,
   output logic        core_run,
   output logic        im_ovf,
   output logic        dm_err
);

   localparam int IM_DEPTH = 1 << IM_AW;
   localparam int DM_DEPTH = 1 << DM_AW;

`ifdef LOAD_CHECKSUM_EN
   typedef enum logic [2:0] {HDR_LO, HDR_HI, LOAD, CHK, RUN} state_t;
   localparam state_t DONE_ST = CHK;
`else
   typedef enum logic [1:0] {HDR_LO, HDR_HI, LOAD, RUN} state_t;
   localparam state_t DONE_ST = RUN;
`endif

   state_t        state, state_nxt;
   logic [15:0]   n_words;
   logic [15:0]   word_cnt;
   logic [1:0]    byte_cnt;
   logic [23:0]   word_buf;     // bytes 0..2 of the word being assembled
   logic          xfer;
   logic          word_done;
   logic          last_word;
   logic          im_wr_ok;
   logic          pc_in_rng;
   logic          dm_in_rng;
   logic [15:0]   hdr_n;
`ifdef LOAD_CHECKSUM_EN
   logic [7:0]    chk_xor;
   logic          chk_ok;
`endif

   logic [31:0]   imem [IM_DEPTH];
   logic [31:0]   dmem [DM_DEPTH];

   assign xfer      = ld_valid && ld_ready;
   assign word_done = (byte_cnt == 2'd3);
   assign last_word = (word_cnt == n_words - 16'd1);
   assign hdr_n     = {ld_byte, n_words[7:0]};
   // Shift-based range checks stay correct even when the address width
   // equals the port width.
   assign im_wr_ok  = ((word_cnt >> IM_AW) == 16'd0);
   assign pc_in_rng = ((PC >> IM_AW) == 32'd0);
   assign dm_in_rng = ((dm_address >> DM_AW) == 16'd0);
`ifdef LOAD_CHECKSUM_EN
   assign chk_ok    = (ld_byte == chk_xor);
`endif

   // ---------------- loader FSM ----------------
   always_ff @(posedge clk or negedge asyn_n_rst) begin
      if (!asyn_n_rst) begin
         state    <= HDR_LO;
         core_run <= 1'b0;
      end else begin
         state    <= state_nxt;
         core_run <= (state_nxt == RUN);
      end
   end

   always_comb begin
      state_nxt = state;
      ld_ready  = (state != RUN);
      case (state)
         HDR_LO: if (xfer) state_nxt = HDR_HI;
         HDR_HI: if (xfer) state_nxt = (hdr_n == 16'd0) ? DONE_ST : LOAD;
         LOAD:   if (xfer && word_done && last_word) state_nxt = DONE_ST;
`ifdef LOAD_CHECKSUM_EN
         CHK:    if (xfer) state_nxt = chk_ok ? RUN : HDR_LO;
`endif
         RUN:    state_nxt = RUN;
         default: state_nxt = HDR_LO;
      endcase
   end

   // ---------------- loader datapath ----------------
   always_ff @(posedge clk or negedge asyn_n_rst) begin
      if (!asyn_n_rst) begin
         n_words  <= 16'd0;
         word_cnt <= 16'd0;
         byte_cnt <= 2'd0;
         word_buf <= 24'd0;
         im_ovf   <= 1'b0;
`ifdef LOAD_CHECKSUM_EN
         chk_xor  <= 8'd0;
`endif
      end else if (xfer) begin
         case (state)
            HDR_LO: begin
               n_words[7:0] <= ld_byte;
               word_cnt     <= 16'd0;
               byte_cnt     <= 2'd0;
`ifdef LOAD_CHECKSUM_EN
               chk_xor      <= ld_byte;
`endif
            end
            HDR_HI: begin
               n_words[15:8] <= ld_byte;
`ifdef LOAD_CHECKSUM_EN
               chk_xor       <= chk_xor ^ ld_byte;
`endif
            end
            LOAD: begin
               byte_cnt <= byte_cnt + 2'd1;
`ifdef LOAD_CHECKSUM_EN
               chk_xor  <= chk_xor ^ ld_byte;
`endif
               case (byte_cnt)
                  2'd0: word_buf[7:0]   <= ld_byte;
                  2'd1: word_buf[15:8]  <= ld_byte;
                  2'd2: word_buf[23:16] <= ld_byte;
                  default: begin
                     word_cnt <= word_cnt + 16'd1;
                     if (!im_wr_ok) im_ovf <= 1'b1;
                  end
               endcase
            end
`ifdef LOAD_CHECKSUM_EN
            CHK: begin
               // A bad checksum restarts the whole image from the header.
               if (!chk_ok) begin
                  word_cnt <= 16'd0;
                  byte_cnt <= 2'd0;
                  chk_xor  <= 8'd0;
               end
            end
`endif
            default: ;
         endcase
      end
   end

   // Memories are deliberately not reset; the next image overwrites imem.
   always_ff @(posedge clk) begin
      if (xfer && (state == LOAD) && word_done && im_wr_ok)
         imem[word_cnt[IM_AW-1:0]] <= {ld_byte, word_buf};
   end

   // ---------------- core side ----------------
   assign instruction = (core_run && pc_in_rng) ? imem[PC[IM_AW-1:0]] : 32'h0;
   assign dm_q        = (core_run && dm_in_rng) ? dmem[dm_address[DM_AW-1:0]] : 32'h0;

   always_ff @(posedge clk) begin
      if (core_run && dm_we && dm_in_rng)
         dmem[dm_address[DM_AW-1:0]] <= dm_d;
   end

   // Any out-of-range address presented while running is an error, load or store.
   always_ff @(posedge clk or negedge asyn_n_rst) begin
      if (!asyn_n_rst)
         dm_err <= 1'b0;
      else if (core_run && !dm_in_rng)
         dm_err <= 1'b1;
   end

endmodule
